ps2_io_port: RTL and testbench

Memory-mapped PS/2 keyboard input port for the CPU's I/O bus. It is the read-direction counterpart to the write-only hex and VGA output devices. The block deserialises PS/2 device-to-host frames into an 8-entry scancode FIFO. The datapath pops scancodes and polls status through the same waddr/raddr/wdata/rdata/wenable bus that the output drivers use, plus a read strobe.

---
 rtl/ps2_io_port_if.sv | 22 ++
 rtl/ps2_io_port.sv | 150 +++++++++++++++
 tb/tb_ps2_io_port.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_io_port_if.sv
// Datapath I/O bus seen by memory-mapped devices.
// master = datapath side, slave = device side.
interface ps2_io_port_if;
  logic [15:0] raddr;
  logic        rread;
  logic [15:0] rdata;
  logic        rsel;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        wenable;
  logic        irq;

  modport master (
    output raddr, rread, waddr, wdata, wenable,
    input  rdata, rsel, irq
  );

  modport slave (
    input  raddr, rread, waddr, wdata, wenable,
    output rdata, rsel, irq
  );
endinterface

// File: rtl/ps2_io_port.sv
// PS/2 keyboard receiver with scancode FIFO,
// mapped onto the datapath I/O bus.
module ps2_io_port #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF10,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 50000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_io_port_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [3:0]  DEPTH4    = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_dat_s1, r_dat_s2;
  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [3:0]    r_count;
  logic          r_ovf, r_ferr;

  logic w_fe, w_dat, w_tout, w_stop_fe;
  logic w_frame_ok, w_frame_bad;
  logic w_stat_wr, w_flush, w_empty, w_full;
  logic w_pop, w_push, w_ovf;
  logic w_unused;

  assign w_fe      = r_clk_prev & ~r_clk_s2;
  assign w_dat     = r_dat_s2;
  assign w_tout    = (r_to == TW'(TIMEOUT)) && !w_fe
                     && (r_state != S_IDLE);
  assign w_stop_fe = (r_state == S_STOP) && w_fe;

  // odd parity: data bits plus parity bit must XOR to 1
  assign w_frame_ok  = w_stop_fe && w_dat && (^r_shift ^ r_par);
  assign w_frame_bad = (w_stop_fe && !w_frame_ok) || w_tout;

  assign w_stat_wr = bus.wenable && (bus.waddr == STAT_ADDR);
  assign w_flush   = w_stat_wr && bus.wdata[15];
  assign w_empty   = (r_count == 4'd0);
  assign w_full    = (r_count == DEPTH4);
  assign w_pop     = bus.rread && (bus.raddr == BASE_ADDR) && !w_empty;
  assign w_push    = w_frame_ok && !w_flush && (!w_full || w_pop);
  assign w_ovf     = w_frame_ok && !w_flush && w_full && !w_pop;
  assign w_unused  = ^{bus.wdata[14:4], bus.wdata[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to       <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat;
      r_dat_s2   <= r_dat_s1;

      if (w_fe || r_state == S_IDLE) r_to <= '0;
      else                           r_to <= r_to + 1'b1;

      if (w_tout) begin
        r_state  <= S_IDLE;
        r_bitcnt <= '0;
      end else if (w_fe) begin
        unique case (r_state)
          S_IDLE: if (!w_dat) begin
            r_state  <= S_DATA;
            r_bitcnt <= '0;
          end
          S_DATA: begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_dat;
            r_state <= S_STOP;
          end
          S_STOP:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end

      // a new error event beats a same-cycle clear
      if (w_ovf)                             r_ovf <= 1'b1;
      else if (w_stat_wr && bus.wdata[2])    r_ovf <= 1'b0;
      if (w_frame_bad)                       r_ferr <= 1'b1;
      else if (w_stat_wr && bus.wdata[3])    r_ferr <= 1'b0;

      if (w_flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
        r_count <= r_count + 4'(w_push) - 4'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= r_shift;
  end

  always_comb begin
    bus.rdata = '0;
    bus.rsel  = 1'b0;
    unique case (1'b1)
      (bus.raddr == BASE_ADDR): begin
        bus.rsel = 1'b1;
        if (!w_empty) bus.rdata = {8'h00, r_mem[r_rp]};
      end
      (bus.raddr == STAT_ADDR): begin
        bus.rsel  = 1'b1;
        bus.rdata = {8'h00, r_count, r_ferr, r_ovf,
                     w_full, !w_empty};
      end
      default: ;
    endcase
  end

  assign bus.irq = !w_empty;
endmodule

// File: tb/tb_ps2_io_port.sv
// Directed bench for ps2_io_port: frames, errors,
// timeout, FIFO corner cases and mid-frame reset.
module tb_ps2_io_port;
  localparam logic [15:0] BASE = 16'hFF10;
  localparam logic [15:0] STAT = 16'hFF11;
  localparam int          TO   = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pclk = 1'b1;
  logic pdat = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ps2_io_port_if bus();

  ps2_io_port #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .TIMEOUT   (TO)
  ) dut (
    .clock  (clk),
    .reset  (rst_n),
    .ps2_clk(pclk),
    .ps2_dat(pdat),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] exp);
    bus.raddr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.raddr = BASE;
    bus.rread = 1'b1;
    @(negedge clk);
    bus.rread = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.waddr   = a;
    bus.wdata   = d;
    bus.wenable = 1'b1;
    @(negedge clk);
    bus.wenable = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    pdat = b;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
    repeat (5) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d,
                                     input logic bad_par,
                                     input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic frame(input logic [7:0] d);
    ps2_bits(mk(d, 1'b0, 1'b1), 11);
    repeat (4) @(negedge clk);
  endtask

  // stop-bit fall lands in the push cycle; kind 1 = pop, 2 = flush
  task automatic frame_with(input logic [7:0] d, input int kind);
    ps2_bits(mk(d, 1'b0, 1'b1), 10);
    @(negedge clk);
    pdat = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
    repeat (2) @(negedge clk);
    if (kind == 1) begin
      bus.raddr = BASE;
      bus.rread = 1'b1;
    end else begin
      bus.waddr   = STAT;
      bus.wdata   = 16'h8000;
      bus.wenable = 1'b1;
    end
    @(negedge clk);
    bus.rread   = 1'b0;
    bus.wenable = 1'b0;
    repeat (3) @(negedge clk);
    pclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.raddr   = 16'h0000;
    bus.rread   = 1'b0;
    bus.waddr   = 16'h0000;
    bus.wdata   = 16'h0000;
    bus.wenable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_irq", {15'd0, bus.irq}, 16'h0000);
    chk_rd("rst_data", BASE, 16'h0000);
    chk_rd("rst_stat", STAT, 16'h0000);
    chk("rsel_base", {15'd0, bus.rsel}, 16'h0001);
    chk_rd("other_addr", 16'h1234, 16'h0000);
    chk("rsel_other", {15'd0, bus.rsel}, 16'h0000);

    frame(8'h1C);
    chk_rd("one_stat", STAT, 16'h0011);
    chk("one_irq", {15'd0, bus.irq}, 16'h0001);
    chk_rd("one_data", BASE, 16'h001C);
    chk_rd("nopop_data", BASE, 16'h001C);
    pop();
    chk_rd("one_popped", STAT, 16'h0000);

    for (int i = 1; i <= 9; i++) frame(8'(i));
    chk_rd("full_stat", STAT, 16'h0087);
    for (int i = 1; i <= 8; i++) begin
      chk_rd($sformatf("order_%0d", i), BASE, 16'(i));
      pop();
    end
    chk_rd("drained_stat", STAT, 16'h0004);
    wr(STAT, 16'h0004);
    chk_rd("ovf_clr", STAT, 16'h0000);

    ps2_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    repeat (4) @(negedge clk);
    chk_rd("par_err", STAT, 16'h0008);
    wr(STAT, 16'h0008);
    chk_rd("ferr_clr", STAT, 16'h0000);
    ps2_bits(mk(8'h2A, 1'b0, 1'b0), 11);
    repeat (4) @(negedge clk);
    chk_rd("stop_err", STAT, 16'h0008);
    wr(STAT, 16'h0008);
    chk_rd("ferr_clr2", STAT, 16'h0000);

    ps2_bits(mk(8'hA5, 1'b0, 1'b1), 5);
    repeat (TO / 2) @(negedge clk);
    chk_rd("to_pending", STAT, 16'h0000);
    repeat (TO / 2 + 20) @(negedge clk);
    chk_rd("to_err", STAT, 16'h0008);
    frame(8'h5A);
    chk_rd("after_to_stat", STAT, 16'h0019);
    chk_rd("after_to_data", BASE, 16'h005A);
    pop();
    wr(STAT, 16'h0008);
    chk_rd("to_clean", STAT, 16'h0000);

    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i));
    chk_rd("refill_stat", STAT, 16'h0083);
    frame_with(8'h18, 1);
    chk_rd("pushpop_stat", STAT, 16'h0083);
    chk_rd("pushpop_head", BASE, 16'h0011);
    frame_with(8'h19, 2);
    chk_rd("flush_stat", STAT, 16'h0000);
    chk_rd("flush_data", BASE, 16'h0000);
    frame(8'h66);
    chk_rd("post_flush", BASE, 16'h0066);
    pop();

    frame(8'h44);
    chk_rd("pre_rst", STAT, 16'h0011);
    ps2_bits(mk(8'h77, 1'b0, 1'b1), 4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_rd("midrst_stat", STAT, 16'h0000);
    frame(8'h33);
    chk_rd("midrst_after", STAT, 16'h0011);
    chk_rd("midrst_data", BASE, 16'h0033);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
